// File: rtl/alu_md_pkg.sv
// Shared opcode encoding, FSM state type and op-class helpers for the
// multi-cycle integer/multiply/divide unit.
package alu_md_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_LT     = 5'd5,
    OP_LTU    = 5'd6,
    OP_GE     = 5'd7,
    OP_GEU    = 5'd8,
    OP_EQ     = 5'd9,
    OP_NE     = 5'd10,
    OP_SLL    = 5'd11,
    OP_SRL    = 5'd12,
    OP_SRA    = 5'd13,
    OP_MUL    = 5'd16,
    OP_MULH   = 5'd17,
    OP_MULHSU = 5'd18,
    OP_MULHU  = 5'd19,
    OP_DIV    = 5'd20,
    OP_DIVU   = 5'd21,
    OP_REM    = 5'd22,
    OP_REMU   = 5'd23
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  function automatic logic is_mul(input logic [4:0] op);
    return op[4:2] == 3'b100;
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return op[4:2] == 3'b101;
  endfunction

endpackage

// File: rtl/alu_md_seq_core.sv
// Iterative datapath shared by multiply (shift-add, MUL_STEP bits/cycle) and
// divide (restoring, 1 bit/cycle) on unsigned magnitudes.
module alu_md_seq_core #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            div_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            last_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);
  localparam int unsigned CW = $clog2(XLEN + 1);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic            div_q, div_d;

  logic [XLEN+MUL_STEP-1:0]   msum;
  logic [2*XLEN+MUL_STEP-1:0] mcat;
  logic [XLEN:0]              rsh;
  logic [XLEN:0]              diff;

  // Multiply: {hi,lo} holds {partial product, unconsumed multiplier bits};
  // divide: hi is the partial remainder, lo shifts dividend out / quotient in.
  always_comb begin
    msum = {{MUL_STEP{1'b0}}, hi_q}
         + ({{MUL_STEP{1'b0}}, opnd_q} * {{XLEN{1'b0}}, lo_q[MUL_STEP-1:0]});
    mcat = {msum, lo_q};
    rsh  = {hi_q, lo_q[XLEN-1]};
    diff = rsh - {1'b0, opnd_q};

    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    div_d  = div_q;

    if (start_i) begin
      div_d  = div_i;
      hi_d   = '0;
      lo_d   = div_i ? a_i : b_i;
      opnd_d = div_i ? b_i : a_i;
      cnt_d  = div_i ? CW'(XLEN) : CW'(XLEN / MUL_STEP);
    end else if (step_i && cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      if (div_q) begin
        if (!diff[XLEN]) begin
          hi_d = diff[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_d = rsh[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        hi_d = mcat[2*XLEN+MUL_STEP-1:XLEN+MUL_STEP];
        lo_d = mcat[XLEN+MUL_STEP-1:MUL_STEP];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
    end
  end

  assign last_o = (cnt_q == CW'(1));
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/alu_md.sv
// Multi-cycle RV32I/RV32M execution unit with valid/ready handshake, tag
// passthrough and kill flush.
module alu_md
  import alu_md_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_STEP = 1,
  parameter int unsigned TAGW     = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [TAGW-1:0] in_tag,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_y,
  output logic [TAGW-1:0] out_tag
);
  localparam int unsigned SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q;
  logic [4:0]      op_q;
  logic            neg_q;
  logic            out_valid_q;
  logic [XLEN-1:0] out_y_q;
  logic [TAGW-1:0] out_tag_q;

  logic            accept, long_op, special, neg_d;
  logic            a_sgn, b_sgn, sa, sb;
  logic [XLEN-1:0] a_mag, b_mag, alu_y, spec_y, fix_y;
  logic [XLEN-1:0] core_hi, core_lo;
  logic            core_last;
  logic [2*XLEN-1:0] prod, prod_s;

  assign in_ready  = (state_q == S_IDLE);
  assign accept    = in_valid & in_ready & ~kill;
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_tag   = out_tag_q;

  always_comb begin
    alu_y = in_a - in_b;
    case (in_op)
      OP_ADD:  alu_y = in_a + in_b;
      OP_SUB:  alu_y = in_a - in_b;
      OP_AND:  alu_y = in_a & in_b;
      OP_OR:   alu_y = in_a | in_b;
      OP_XOR:  alu_y = in_a ^ in_b;
      OP_LT:   alu_y = {{(XLEN-1){1'b0}}, $signed(in_a) <  $signed(in_b)};
      OP_LTU:  alu_y = {{(XLEN-1){1'b0}}, in_a <  in_b};
      OP_GE:   alu_y = {{(XLEN-1){1'b0}}, $signed(in_a) >= $signed(in_b)};
      OP_GEU:  alu_y = {{(XLEN-1){1'b0}}, in_a >= in_b};
      OP_EQ:   alu_y = {{(XLEN-1){1'b0}}, in_a == in_b};
      OP_NE:   alu_y = {{(XLEN-1){1'b0}}, in_a != in_b};
      OP_SLL:  alu_y = in_a << in_b[SHW-1:0];
      OP_SRL:  alu_y = in_a >> in_b[SHW-1:0];
      OP_SRA:  alu_y = $signed(in_a) >>> in_b[SHW-1:0];
      default: alu_y = in_a - in_b;
    endcase
  end

  // Operand magnitudes, result-sign flag and the division corner cases that
  // bypass the iterative core entirely.
  always_comb begin
    a_sgn = (in_op == OP_MULH) || (in_op == OP_MULHSU) ||
            (in_op == OP_DIV)  || (in_op == OP_REM);
    b_sgn = (in_op == OP_MULH) || (in_op == OP_DIV) || (in_op == OP_REM);
    sa    = a_sgn & in_a[XLEN-1];
    sb    = b_sgn & in_b[XLEN-1];
    a_mag = sa ? -in_a : in_a;
    b_mag = sb ? -in_b : in_b;

    neg_d = 1'b0;
    case (in_op)
      OP_MULH, OP_DIV:  neg_d = sa ^ sb;
      OP_MULHSU, OP_REM: neg_d = sa;
      default:          neg_d = 1'b0;
    endcase

    special = 1'b0;
    spec_y  = '0;
    if (is_div(in_op)) begin
      if (in_b == '0) begin
        special = 1'b1;
        spec_y  = ((in_op == OP_REM) || (in_op == OP_REMU)) ? in_a : '1;
      end else if (b_sgn && in_a == MINV && in_b == '1) begin
        special = 1'b1;
        spec_y  = (in_op == OP_DIV) ? in_a : '0;
      end
    end
    long_op = (is_mul(in_op) | is_div(in_op)) & ~special;
  end

  always_comb begin
    prod   = {core_hi, core_lo};
    prod_s = neg_q ? -prod : prod;
    fix_y  = neg_q ? -core_lo : core_lo;
    case (op_q)
      OP_MUL:                       fix_y = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_y = prod_s[2*XLEN-1:XLEN];
      OP_REM, OP_REMU:              fix_y = neg_q ? -core_hi : core_hi;
      default:                      fix_y = neg_q ? -core_lo : core_lo;
    endcase
  end

  alu_md_seq_core #(
    .XLEN     (XLEN),
    .MUL_STEP (MUL_STEP)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .start_i (accept & long_op),
    .div_i   (is_div(in_op)),
    .step_i  (state_q == S_CALC),
    .a_i     (a_mag),
    .b_i     (b_mag),
    .last_o  (core_last),
    .hi_o    (core_hi),
    .lo_o    (core_lo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_tag_q   <= '0;
    end else if (kill) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            out_tag_q <= in_tag;
            op_q      <= in_op;
            neg_q     <= neg_d;
            if (long_op) begin
              state_q <= S_CALC;
            end else begin
              out_y_q     <= special ? spec_y : alu_y;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_CALC: begin
          if (core_last) state_q <= S_FIX;
        end
        S_FIX: begin
          out_y_q     <= fix_y;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md.sv
// Directed self-checking bench for alu_md: MUL_STEP=1 instance plus a
// MUL_STEP=4 instance sharing the operand, kill and reset inputs.
module tb_alu_md;
  import alu_md_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned TAGW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_valid4;
  logic            in_ready, in_ready4;
  logic [4:0]      in_op;
  logic [XLEN-1:0] in_a, in_b;
  logic [TAGW-1:0] in_tag;
  logic            kill;
  logic            out_valid, out_valid4;
  logic            out_ready, out_ready4;
  logic [XLEN-1:0] out_y, out_y4;
  logic [TAGW-1:0] out_tag, out_tag4;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  alu_md #(.XLEN(XLEN), .MUL_STEP(1), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .kill(kill),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_tag(out_tag)
  );

  alu_md #(.XLEN(XLEN), .MUL_STEP(4), .TAGW(TAGW)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .kill(kill),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_y(out_y4), .out_tag(out_tag4)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait (bounded) for the result, check value/tag/latency,
  // then take it and check in_ready comes back.
  task automatic run_op(input string name, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] exp_y,
                        input int lat_exp, input bit use4);
    int lat;
    bit got;
    in_op = op; in_a = a; in_b = b; in_tag = tag;
    if (use4) in_valid4 = 1'b1; else in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_valid4 = 1'b0;
    in_a = ~a; in_b = ~b; in_tag = ~tag;
    lat = 1;
    got = 1'b0;
    while (!got && lat < 100) begin
      if (use4 ? out_valid4 : out_valid) got = 1'b1;
      else begin
        step();
        lat++;
      end
    end
    chk({name, " valid"}, 32'(got), 32'd1);
    chk({name, " y"}, use4 ? out_y4 : out_y, exp_y);
    chk({name, " tag"}, 32'(use4 ? out_tag4 : out_tag), 32'(tag));
    chk({name, " latency"}, 32'(lat), 32'(lat_exp));
    if (use4) out_ready4 = 1'b1; else out_ready = 1'b1;
    step();
    out_ready = 1'b0; out_ready4 = 1'b0;
    chk({name, " in_ready after"}, 32'(use4 ? in_ready4 : in_ready), 32'd1);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; in_valid = 1'b0; in_valid4 = 1'b0; in_op = '0; in_a = '0;
    in_b = '0; in_tag = '0; kill = 1'b0; out_ready = 1'b0; out_ready4 = 1'b0;
    repeat (2) step();
    chk("rst in_ready",  32'(in_ready),  32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_y",     out_y,          32'd0);
    chk("rst out_tag",   32'(out_tag),   32'd0);
    rst = 1'b0;
    step();

    // Single-cycle ops
    run_op("ADD",    OP_ADD, 32'h7FFFFFFF, 32'h1,        5'd1, 32'h80000000, 1, 1'b0);
    run_op("SUB",    OP_SUB, 32'd5,        32'd7,        5'd2, 32'hFFFFFFFE, 1, 1'b0);
    run_op("XOR",    OP_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 5'd3, 32'h0FF00FF0, 1, 1'b0);
    run_op("LTU",    OP_LTU, 32'd1,        32'hFFFFFFFF, 5'd4, 32'd1,        1, 1'b0);
    run_op("LT",     OP_LT,  32'hFFFFFFFF, 32'd1,        5'd5, 32'd1,        1, 1'b0);
    run_op("GE",     OP_GE,  32'hFFFFFFFF, 32'd1,        5'd6, 32'd0,        1, 1'b0);
    run_op("EQ",     OP_EQ,  32'd5,        32'd5,        5'd7, 32'd1,        1, 1'b0);
    run_op("NE",     OP_NE,  32'd5,        32'd5,        5'd8, 32'd0,        1, 1'b0);
    run_op("SLL",    OP_SLL, 32'd1,        32'd35,       5'd9, 32'd8,        1, 1'b0);
    run_op("SRL",    OP_SRL, 32'h80000000, 32'd31,       5'd10, 32'd1,       1, 1'b0);
    run_op("SRA",    OP_SRA, 32'h80000000, 32'd4,        5'd11, 32'hF8000000, 1, 1'b0);
    run_op("UNDEF",  5'd14,  32'd10,       32'd3,        5'd12, 32'd7,       1, 1'b0);

    // Multiply, MUL_STEP=1 and MUL_STEP=4
    run_op("MULH",   OP_MULH,   32'h80000000, 32'h80000000, 5'd13, 32'h40000000, 34, 1'b0);
    run_op("MULHU",  OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd14, 32'hFFFFFFFE, 34, 1'b0);
    run_op("MUL",    OP_MUL,    32'd7,        32'hFFFFFFFD, 5'd15, 32'hFFFFFFEB, 34, 1'b0);
    run_op("MULHSU", OP_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd16, 32'hFFFFFFFF, 34, 1'b0);
    run_op("MULH4",  OP_MULH,   32'h80000000, 32'h80000000, 5'd17, 32'h40000000, 10, 1'b1);
    run_op("MULHU4", OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd18, 32'hFFFFFFFE, 10, 1'b1);
    run_op("MUL4",   OP_MUL,    32'd7,        32'hFFFFFFFD, 5'd19, 32'hFFFFFFEB, 10, 1'b1);

    // Divide, including the single-cycle corner cases
    run_op("DIV",    OP_DIV,  32'hFFFFFFF9, 32'd2, 5'd20, 32'hFFFFFFFD, 34, 1'b0);
    run_op("REM",    OP_REM,  32'hFFFFFFF9, 32'd2, 5'd21, 32'hFFFFFFFF, 34, 1'b0);
    run_op("DIVU",   OP_DIVU, 32'd100,      32'd7, 5'd22, 32'd14,       34, 1'b0);
    run_op("REMU",   OP_REMU, 32'd100,      32'd7, 5'd23, 32'd2,        34, 1'b0);
    run_op("DIVU/0", OP_DIVU, 32'd5, 32'd0, 5'd24, 32'hFFFFFFFF, 1, 1'b0);
    run_op("REM/0",  OP_REM,  32'd5, 32'd0, 5'd25, 32'd5,        1, 1'b0);
    run_op("DIV ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd26, 32'h80000000, 1, 1'b0);
    run_op("REM ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 5'd27, 32'd0,        1, 1'b0);

    // Consumer stall in DONE
    in_op = OP_ADD; in_a = 32'd3; in_b = 32'd4; in_tag = 5'd9; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_a = 32'd100; in_tag = 5'd0;
    for (int i = 0; i < 5; i++) begin
      chk("stall out_valid", 32'(out_valid), 32'd1);
      chk("stall out_y",     out_y,          32'd7);
      chk("stall out_tag",   32'(out_tag),   32'd9);
      chk("stall in_ready",  32'(in_ready),  32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("xfer out_valid", 32'(out_valid), 32'd0);
    chk("xfer in_ready",  32'(in_ready),  32'd1);

    // kill at CALC cycle 10 of a DIV
    in_op = OP_DIV; in_a = 32'd100; in_b = 32'd7; in_tag = 5'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    chk("kill pre in_ready", 32'(in_ready), 32'd0);
    kill = 1'b1;
    step();
    kill = 1'b0;
    chk("kill in_ready",  32'(in_ready),  32'd1);
    chk("kill out_valid", 32'(out_valid), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen |= out_valid;
      step();
    end
    chk("kill no result", 32'(seen), 32'd0);

    // kill beats in_valid in IDLE
    in_op = OP_ADD; in_a = 32'd1; in_b = 32'd1; in_valid = 1'b1; kill = 1'b1;
    step();
    in_valid = 1'b0; kill = 1'b0;
    chk("kill-vs-valid in_ready",  32'(in_ready),  32'd1);
    chk("kill-vs-valid out_valid", 32'(out_valid), 32'd0);

    // kill beats out_ready in DONE
    in_op = OP_ADD; in_a = 32'd2; in_b = 32'd2; in_tag = 5'd6; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("kill-done pre valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1; kill = 1'b1;
    step();
    out_ready = 1'b0; kill = 1'b0;
    chk("kill-done out_valid", 32'(out_valid), 32'd0);
    chk("kill-done in_ready",  32'(in_ready),  32'd1);

    // async reset in the middle of a MUL
    in_op = OP_MUL; in_a = 32'd7; in_b = 32'd3; in_tag = 5'd21; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    #2 rst = 1'b1;
    #1;
    chk("rst-mid in_ready",  32'(in_ready),  32'd1);
    chk("rst-mid out_valid", 32'(out_valid), 32'd0);
    chk("rst-mid out_y",     out_y,          32'd0);
    chk("rst-mid out_tag",   32'(out_tag),   32'd0);
    step();
    rst = 1'b0;
    step();
    run_op("MUL after rst", OP_MUL, 32'd7, 32'd3, 5'd22, 32'd21, 34, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
